// File: rtl/ps2_scancode_rx.sv
// PS/2 set-2 keyboard receiver: conditions the pins, deframes bytes and folds E0/F0/E1 prefixes
// into single 11-bit key events. Define PS2_TIMEOUT_EN to abort frames that stall mid-byte.
module ps2_scancode_rx #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 64000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int unsigned FW = $clog2(FILTER + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic          clk_filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          strobe;

    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          byte_valid;
    logic [7:0]    rx_byte;
    logic          timeout_hit;

    logic          ext;
    logic          brk;
    logic [2:0]    skip;

    // Pin synchronisers and clock deglitch filter; idle line level is high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync      <= 2'b11;
            data_sync     <= 2'b11;
            clk_filt      <= 1'b1;
            clk_filt_prev <= 1'b1;
            filt_cnt      <= '0;
        end else begin
            clk_sync      <= {clk_sync[0], ps2_clk};
            data_sync     <= {data_sync[0], ps2_data};
            clk_filt_prev <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign strobe = clk_filt_prev & ~clk_filt;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= StIdle;
            bitcnt     <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_hit <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            timeout_hit <= 1'b0;
            if (state == StIdle || strobe) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
`endif
            if (strobe) begin
                unique case (state)
                    StIdle: begin
                        if (!data_sync[1]) begin
                            state  <= StData;
                            bitcnt <= '0;
                        end
                    end
                    StData: begin
                        shreg  <= {data_sync[1], shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= StParity;
                        end
                    end
                    StParity: begin
                        par_bit <= data_sync[1];
                        state   <= StStop;
                    end
                    StStop: begin
                        // Odd parity across the eight data bits plus the parity bit.
                        if (data_sync[1] && (^{shreg, par_bit})) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
`ifdef PS2_TIMEOUT_EN
            else if (state != StIdle && to_cnt == TW'(TIMEOUT - 1)) begin
                state       <= StIdle;
                timeout_hit <= 1'b1;
            end
`endif
        end
    end

    // Prefix folding and event generation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ps2_key <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            skip    <= '0;
        end else if (timeout_hit) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            skip <= '0;
        end else if (byte_valid) begin
            if (skip != 3'd0) begin
                skip <= skip - 3'd1;
            end else if (rx_byte == 8'hE1) begin
                skip <= 3'd7;
            end else if (rx_byte == 8'hE0) begin
                ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk <= 1'b1;
            end else if (ext && (rx_byte == 8'h12 || rx_byte == 8'h59)) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (!ext && !brk &&
                         (rx_byte inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
                // Keyboard housekeeping responses carry no key information.
                ext <= 1'b0;
            end else begin
                ps2_key <= {~ps2_key[10], ~brk, ext, rx_byte};
                ext     <= 1'b0;
                brk     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames on the pins and checks key events
// against hand-computed words.
module tb_ps2_scancode_rx;

    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   err_cycles = 0;
    int   e0;
    logic tog;

    ps2_scancode_rx #(
        .FILTER (FILTER),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_cycles++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic par,
                                             input logic stop);
        return {stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2_data = f[i];
            wait_clk(10);
            ps2_clk = 1'b0;
            wait_clk(20);
            ps2_clk = 1'b1;
            wait_clk(10);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame_of(b, ~^b, 1'b1), 0, 10);
        wait_clk(30);
    endtask

    // Expect a new event: toggle flips, low ten bits as given.
    task automatic expect_event(input string tag, input logic [9:0] low);
        tog = ~tog;
        check_eq(tag, {5'b0, ps2_key}, {5'b0, tog, low});
    endtask

    task automatic expect_hold(input string tag, input logic [9:0] low);
        check_eq(tag, {5'b0, ps2_key}, {5'b0, tog, low});
    endtask

    initial begin
        tog = 1'b0;
        wait_clk(4);
        check_eq("reset_key", {5'b0, ps2_key}, 16'h0000);
        check_eq("reset_err", {15'b0, frame_err}, 16'h0000);
        reset_n = 1'b1;
        wait_clk(4);

        send_byte(8'h1C);
        expect_event("make_1c", 10'h21C);
        check_eq("no_err_1c", 16'(err_cycles), 16'd0);

        send_byte(8'hF0);
        expect_hold("f0_no_event", 10'h21C);
        send_byte(8'h1C);
        expect_event("break_1c", 10'h01C);

        send_byte(8'hE0);
        send_byte(8'h75);
        expect_event("ext_make_75", 10'h375);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        expect_event("ext_break_75", 10'h175);

        send_byte(8'h1C);
        expect_event("repeat_1", 10'h21C);
        send_byte(8'h1C);
        expect_event("repeat_2", 10'h21C);

        send_byte(8'hAA);
        expect_hold("bat_dropped", 10'h21C);
        send_byte(8'hE0);
        send_byte(8'h12);
        expect_hold("fake_shift_dropped", 10'h21C);
        send_byte(8'h1C);
        expect_event("after_fake_shift", 10'h21C);

        // 0x29 has three ones, so parity bit 1 makes the total even.
        e0 = err_cycles;
        send_bits(frame_of(8'h29, 1'b1, 1'b1), 0, 10);
        wait_clk(30);
        check_eq("parity_err_pulse", 16'(err_cycles - e0), 16'd1);
        expect_hold("parity_err_key", 10'h21C);

        send_byte(8'hE0);
        e0 = err_cycles;
        send_bits(frame_of(8'h29, 1'b0, 1'b0), 0, 10);
        wait_clk(30);
        check_eq("stop_err_pulse", 16'(err_cycles - e0), 16'd1);
        send_byte(8'h75);
        expect_event("ext_kept_over_err", 10'h375);

        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        expect_hold("pause_silent", 10'h375);
        send_byte(8'h16);
        expect_event("after_pause", 10'h216);

        // Clock glitch shorter than the filter while data looks like a start bit.
        ps2_data = 1'b0;
        wait_clk(5);
        ps2_clk = 1'b0;
        wait_clk(FILTER - 2);
        ps2_clk = 1'b1;
        wait_clk(5);
        ps2_data = 1'b1;
        wait_clk(30);
        send_byte(8'h1C);
        expect_event("after_glitch", 10'h21C);

        // Stall after start bit and four data bits.
        send_bits(frame_of(8'h1C, 1'b0, 1'b1), 0, 4);
        wait_clk(TIMEOUT + 100);
`ifdef PS2_TIMEOUT_EN
        send_byte(8'h1C);
`else
        send_bits(frame_of(8'h1C, 1'b0, 1'b1), 5, 10);
        wait_clk(30);
`endif
        expect_event("after_stall", 10'h21C);
        check_eq("stall_no_err", 16'(err_cycles - e0), 16'd1);

        // Reset in the middle of a frame.
        send_bits(frame_of(8'h1C, 1'b0, 1'b1), 0, 4);
        reset_n = 1'b0;
        wait_clk(1);
        check_eq("midframe_reset_key", {5'b0, ps2_key}, 16'h0000);
        check_eq("midframe_reset_err", {15'b0, frame_err}, 16'h0000);
        reset_n = 1'b1;
        tog = 1'b0;
        wait_clk(4);
        send_byte(8'h1C);
        expect_event("after_reset", 10'h21C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
